// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory-wait freezes.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] IF_ID_instruction_i,
  input  logic [31:0] ID_EX_instruction_i,
  input  logic        ID_EX_memRead_i,
  input  logic        EX_MEM_branch_taken_i,
  input  logic        mem_busy_i,
  output logic        pc_write_o,
  output logic        IF_ID_write_o,
  output logic        IF_ID_flush_o,
  output logic        ID_EX_flush_o,
  output logic        EX_MEM_flush_o,
  output logic        freeze_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FLUSH    = 2'b10,
    MEM_WAIT = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic       pending_q, pending_d;
  logic [4:0] if_rs, if_rt, ex_rt;
  logic       load_use;
  logic       unused_bits;

  assign if_rs = IF_ID_instruction_i[25:21];
  assign if_rt = IF_ID_instruction_i[20:16];
  assign ex_rt = ID_EX_instruction_i[20:16];

  assign unused_bits = ^{IF_ID_instruction_i[31:26], IF_ID_instruction_i[15:0],
                         ID_EX_instruction_i[31:21], ID_EX_instruction_i[15:0]};

  assign load_use = ID_EX_memRead_i && (ex_rt != 5'd0) &&
                    ((ex_rt == if_rs) || (ex_rt == if_rt));

  // Priority: memory freeze, then branch flush (including one deferred by a freeze), then load-use.
  always_comb begin
    state_d        = RUN;
    pending_d      = pending_q;
    pc_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_flush_o  = 1'b0;
    EX_MEM_flush_o = 1'b0;
    freeze_o       = 1'b0;
    if (!rst_i) begin
      pending_d = 1'b0;
    end else if (mem_busy_i) begin
      state_d       = MEM_WAIT;
      freeze_o      = 1'b1;
      pc_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      if (EX_MEM_branch_taken_i)
        pending_d = 1'b1;
    end else if (EX_MEM_branch_taken_i || pending_q) begin
      state_d        = FLUSH;
      pending_d      = 1'b0;
      IF_ID_flush_o  = 1'b1;
      ID_EX_flush_o  = 1'b1;
      EX_MEM_flush_o = 1'b1;
    end else if (load_use) begin
      state_d       = LU_STALL;
      pc_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      ID_EX_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Both counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (((state_d == LU_STALL) || (state_d == MEM_WAIT)) && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if ((state_d == FLUSH) && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
  assign flush_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] IF_ID_instruction_i, ID_EX_instruction_i;
  logic        ID_EX_memRead_i, EX_MEM_branch_taken_i, mem_busy_i;
  logic        pc_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_flush_o, EX_MEM_flush_o, freeze_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int total = 0;
  int bad   = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Reference model state: last action, deferred flush flag, event counts.
  int m_state   = 0;
  int m_pending = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .IF_ID_instruction_i   (IF_ID_instruction_i),
    .ID_EX_instruction_i   (ID_EX_instruction_i),
    .ID_EX_memRead_i       (ID_EX_memRead_i),
    .EX_MEM_branch_taken_i (EX_MEM_branch_taken_i),
    .mem_busy_i            (mem_busy_i),
    .pc_write_o            (pc_write_o),
    .IF_ID_write_o         (IF_ID_write_o),
    .IF_ID_flush_o         (IF_ID_flush_o),
    .ID_EX_flush_o         (ID_EX_flush_o),
    .EX_MEM_flush_o        (EX_MEM_flush_o),
    .freeze_o              (freeze_o),
    .state_o               (state_o),
    .stall_cnt_o           (stall_cnt_o),
    .flush_cnt_o           (flush_cnt_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] instr(input int rs, input int rt);
    logic [31:0] w;
    w = $urandom;
    w[25:21] = rs[4:0];
    w[20:16] = rt[4:0];
    return w;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, then registered ones after the edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] ifi, input logic [31:0] exi,
                               input logic mr, input logic br, input logic busy);
    int action;
    int ex_rt, lu;
    rst_i = rst; IF_ID_instruction_i = ifi; ID_EX_instruction_i = exi;
    ID_EX_memRead_i = mr; EX_MEM_branch_taken_i = br; mem_busy_i = busy;
    #1;
    ex_rt = int'(exi[20:16]);
    lu = (mr && ex_rt != 0 && (ex_rt == int'(ifi[25:21]) || ex_rt == int'(ifi[20:16]))) ? 1 : 0;
    if (!rst)                    action = 0;
    else if (busy)               action = 3;
    else if (br || m_pending!=0) action = 2;
    else if (lu != 0)            action = 1;
    else                         action = 0;
    checkOutput("pc_write",  {31'd0, pc_write_o},     (action == 0 || action == 2) ? 1 : 0);
    checkOutput("ifid_write",{31'd0, IF_ID_write_o},  (action == 0 || action == 2) ? 1 : 0);
    checkOutput("ifid_flush",{31'd0, IF_ID_flush_o},  (action == 2) ? 1 : 0);
    checkOutput("idex_flush",{31'd0, ID_EX_flush_o},  (action == 1 || action == 2) ? 1 : 0);
    checkOutput("exmem_flush",{31'd0, EX_MEM_flush_o},(action == 2) ? 1 : 0);
    checkOutput("freeze",    {31'd0, freeze_o},       (action == 3) ? 1 : 0);
    @(posedge clk_i);
    if (!rst) begin
      m_state = 0; m_pending = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_state = action;
      if (busy) m_pending = (m_pending != 0 || br) ? 1 : 0;
      else      m_pending = 0;
      if (CNT_EN && (action == 1 || action == 3)) m_stall = sat_add(m_stall, 1);
      if (CNT_EN && action == 2) m_flush = sat_add(m_flush, 1);
    end
    #1;
    checkOutput("state",     {30'd0, state_o},     m_state);
    checkOutput("stall_cnt", {16'd0, stall_cnt_o}, m_stall);
    checkOutput("flush_cnt", {16'd0, flush_cnt_o}, m_flush);
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] lw2, add324, lw0, nop;
    rst_i = 1'b0; IF_ID_instruction_i = '0; ID_EX_instruction_i = '0;
    ID_EX_memRead_i = 0; EX_MEM_branch_taken_i = 0; mem_busy_i = 0;
    lw2 = 32'h8C02_0000; add324 = 32'h0044_1820; lw0 = 32'h8C00_0000; nop = 32'h0;
    @(negedge clk_i);

    applyStimulus(0, nop, nop, 0, 0, 0);
    applyStimulus(1, nop, nop, 0, 0, 0);

    // Load-use on $2, then the bubble removes memRead.
    applyStimulus(1, add324, lw2, 1, 0, 0);
    checkOutput("lu_state_01", {30'd0, state_o}, 1);
    applyStimulus(1, add324, nop, 0, 0, 0);

    // Load into $0 never stalls.
    applyStimulus(1, instr(0, 5), lw0, 1, 0, 0);
    checkOutput("lw0_state_00", {30'd0, state_o}, 0);

    // Branch beats load-use in the same cycle.
    applyStimulus(1, add324, lw2, 1, 1, 0);
    checkOutput("br_lu_state_10", {30'd0, state_o}, 2);
    // Back-to-back branches each flush.
    applyStimulus(1, nop, nop, 0, 1, 0);
    applyStimulus(1, nop, nop, 0, 1, 0);

    // Three busy cycles with a branch in the second; the flush lands in cycle 4.
    applyStimulus(1, nop, nop, 0, 0, 1);
    applyStimulus(1, nop, nop, 0, 1, 1);
    applyStimulus(1, nop, nop, 0, 0, 1);
    applyStimulus(1, nop, nop, 0, 0, 0);
    checkOutput("deferred_flush_state", {30'd0, state_o}, 2);
    applyStimulus(1, nop, nop, 0, 0, 0);

    // Reset in MEM_WAIT with a pending flush discards it.
    applyStimulus(1, nop, nop, 0, 1, 1);
    applyStimulus(0, nop, nop, 0, 0, 1);
    checkOutput("rst_mid_wait_state", {30'd0, state_o}, 0);
    applyStimulus(1, nop, nop, 0, 0, 0);
    checkOutput("no_flush_after_rst", {30'd0, state_o}, 0);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 24) != 0),
                    instr($urandom_range(0, 3), $urandom_range(0, 3)),
                    instr($urandom_range(0, 31), $urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) == 0);
    end

    // Long load-use run to saturate the stall counter.
    applyStimulus(0, nop, nop, 0, 0, 0);
    rst_i = 1; IF_ID_instruction_i = add324; ID_EX_instruction_i = lw2;
    ID_EX_memRead_i = 1; EX_MEM_branch_taken_i = 0; mem_busy_i = 0;
    repeat (70000) @(posedge clk_i);
    #1;
    if (CNT_EN) m_stall = sat_add(m_stall, 70000);
    checkOutput("long_stall_cnt", {16'd0, stall_cnt_o}, CNT_EN ? 32'h0000_FFFF : 32'h0);
    checkOutput("long_stall_model", {16'd0, stall_cnt_o}, m_stall);
    checkOutput("long_stall_state", {30'd0, state_o}, 1);
    checkOutput("long_flush_cnt", {16'd0, flush_cnt_o}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
